// File: rtl/rr_arbiter_8.sv
// Eight-requester round-robin arbiter with optional per-tenure hold limit.
// Latency: request sampled at edge k yields a registered grant after edge k; handoff has no dead cycle.
// Backpressure: en_i low blocks new grants only; an active tenure runs until release or timeout.
module rr_arbiter_8 #(
  parameter int N_REQ    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [2:0]       gnt_idx_o,
  output logic             gnt_valid_o
);

  localparam int IW = 3;
  localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    gnt_idx_q, gnt_idx_d;
  logic [IW-1:0]    last_q, last_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;

  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] cand;
  logic             win_found;
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    scan_idx;
  logic             owner_req;
  logic             timeout;

  // The owner is only masked out when it is being released; in IDLE everyone competes.
  assign mask      = (state_q == GRANT) ? ~(N_REQ'(1) << gnt_idx_q) : {N_REQ{1'b1}};
  assign cand      = req_i & mask;
  assign owner_req = req_i[gnt_idx_q];
  assign timeout   = (MAX_HOLD != 0) && (hold_cnt_q == HW'(MAX_HOLD));

  // Rotating priority search: first candidate at or after last+1, wrapping modulo 8.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    scan_idx  = last_q;
    for (int i = 1; i <= N_REQ; i++) begin
      scan_idx = last_q + IW'(i);
      if (!win_found && cand[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Next-state decision: start, continue, hand off, or drop the grant.
  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    last_d      = last_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    case (state_q)
      IDLE: begin
        if (en_i && win_found) begin
          state_d     = GRANT;
          gnt_idx_d   = win_idx;
          last_d      = win_idx;
          hold_cnt_d  = HW'(1);
          gnt_d       = N_REQ'(1) << win_idx;
          gnt_valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (owner_req && !timeout) begin
          // With no limit the counter just saturates; it never forces a release.
          if (hold_cnt_q != {HW{1'b1}}) hold_cnt_d = hold_cnt_q + HW'(1);
        end else if (en_i && win_found) begin
          gnt_idx_d   = win_idx;
          last_d      = win_idx;
          hold_cnt_d  = HW'(1);
          gnt_d       = N_REQ'(1) << win_idx;
          gnt_valid_d = 1'b1;
        end else begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset points the search at requester 0 first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      gnt_idx_q   <= '0;
      last_q      <= IW'(N_REQ - 1);
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_idx_q   <= gnt_idx_d;
      last_q      <= last_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = gnt_idx_q;
  assign gnt_valid_o = gnt_valid_q;

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Eight-requester round-robin arbiter that shares one downstream resource and drives it with a one-hot grant vector, which is the decoded form of the registered winner index. It sits between up to eight request sources and a single shared datapath, and owns the sequencing decision for that datapath. Fairness is round-robin: after each grant, the search starts at the requester after the last winner. An optional hold limit bounds how long any requester can keep the resource.

## Interface
- `N_REQ`, 8, number of requesters; fixed at 8 (3-bit index).
- `MAX_HOLD`, 16, maximum consecutive grant cycles per tenure; 0 means unlimited. Hold counter width is `$clog2(MAX_HOLD+1)`, minimum 1.

- `clk`, in, 1, rising-edge clock.
- `rst`, in, 1, synchronous, active-high reset.
- `en`, in, 1, arbitration enable; when low, no new grant is issued.
- `req`, in, 8, per-requester request, level-sensitive.
- `gnt`, out, 8, one-hot grant; all zero when nothing is granted.
- `gnt_idx`, out, 3, index of the current winner; holds its last value when idle.
- `gnt_valid`, out, 1, a grant is active; equals `|gnt`.

## Operation
- The FSM has two states:
  - **IDLE**: no grant is active.
  - **GRANT**: one requester owns the resource.
- Registers: `state`, `gnt_idx`, `last` (3 bits, last winner), `hold_cnt`.
- **Winner search:**
  - Scan `req & mask` starting at `last+1` and wrapping modulo 8. The first set bit wins.
  - `mask` is all ones, except during a GRANT release, when bit `gnt_idx` is cleared.
- **IDLE:**
  - If `en` is high and any `req` bit is set: go to GRANT, load the winner into `gnt_idx` and `last`, and set `hold_cnt=1`.
  - Otherwise stay in IDLE.
- **GRANT, continue:** if `req[gnt_idx]` is high and (`MAX_HOLD==0` or `hold_cnt<MAX_HOLD`), stay in GRANT and increment `hold_cnt`. The counter saturates when `MAX_HOLD==0`.
- **GRANT, release:** release happens when `req[gnt_idx]` is low, or when `hold_cnt==MAX_HOLD` (timeout). On release:
  - If `en` is high and a masked winner exists: hand off directly. Load the new winner, set `hold_cnt=1`, and stay in GRANT.
  - Otherwise go to IDLE.
- The current owner is masked for the release cycle only. A timed-out requester that is the only one requesting therefore gets one idle cycle and is then re-granted.
- `en` low never truncates an active tenure. It only blocks new grants, both from IDLE and at handoff.
- `gnt = gnt_valid ? (8'b1 << gnt_idx) : 8'b0`. This is the decoder function; exactly one bit or zero bits are set.
- `req` bits for non-owners are ignored during a tenure.

## Timing
- All outputs are registered. There is no combinational path from `req` to `gnt`.
- **Reset** (`rst` high at a clock edge): `state=IDLE`, `gnt=8'h00`, `gnt_valid=0`, `gnt_idx=0`, `last=7` (so the first search starts at requester 0), `hold_cnt=0`.
- `rst` has priority over all other inputs. Asserting it mid-tenure drops the grant at the next edge.
- **Grant latency:** a `req` sampled at edge k produces `gnt` valid after edge k, i.e. one cycle.
- **Release latency:** the owner's `req` sampled low at edge k:
  - With another requester pending, the new `gnt` is present after edge k. There is zero dead cycles on handoff.
  - With nothing pending, `gnt` is 0 after edge k.
- **Timeout:** the owner holds `gnt` for exactly `MAX_HOLD` cycles. The release decision is made at the edge where `hold_cnt==MAX_HOLD`.
- **Simultaneous events:** the owner releasing while other requests are set is resolved purely by the rotating search; no request is lost.
- Requesters must hold `req` until granted. Dropping `req` before the grant is legal and simply withdraws the request.

## Test plan
- **Reset:** `rst=1` for 2 cycles with `req=8'hFF` → `gnt=00`, `gnt_valid=0` throughout. After `rst` falls with `en=1`, `gnt=01` one cycle later.
- **Round-robin rotation:** `req=8'hFF`, `MAX_HOLD=0`; each owner drops its `req` bit for one cycle after 3 cycles of grant, then re-raises it → grant order is 01, 02, 04, …, 80, 01 with no idle cycles between owners.
- **Wrap and skip:** `last=6`, `req=8'h05` → `gnt=01`. Release, then → `gnt=04`. Release with `req=0` → `gnt=00` the next cycle.
- **Timeout:** `MAX_HOLD=4`, `req=8'h08` held constant → `gnt=08` for 4 cycles, `00` for 1 cycle, then `08` again; the pattern repeats.
- **Timeout handoff:** `MAX_HOLD=4`, `req=8'h09` → `gnt=01` for 4 cycles, then `08` for 4 cycles, then `01`, with no gap.
- **Enable and mid-reset:**
  - With `gnt=02` active, drop `en` → the grant persists until `req[1]` falls, then `gnt=00` while `req=8'h10` and `en=0`. Raising `en` → `gnt=10` one cycle later.
  - Asserting `rst` while `gnt=10` → `gnt=00` at the next edge.
